// File: rtl/leaf_stream_interface.sv
// Leaf-side BFT packet interface: decodes config/data/credit packets, buffers rx data
// in a FWFT FIFO, returns credits upstream and packs the tx stream into credit-limited packets.
module leaf_stream_interface #(
    parameter int FIFO_DEPTH   = 16,
    parameter int CREDIT_BATCH = 4,
    parameter int INIT_CREDITS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [48:0] din_leaf_bft2interface,
    output logic [48:0] dout_leaf_interface2bft,
    input  logic        resend,
    input  logic        ap_start,
    output logic [31:0] rx_tdata,
    output logic        rx_tvalid,
    input  logic        rx_tready,
    input  logic [31:0] tx_tdata,
    input  logic        tx_tvalid,
    output logic        tx_tready,
    output logic        cfg_done,
    output logic        overflow,
    output logic [1:0]  dbg_state
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CONS_MAX = (FIFO_DEPTH > 127) ? 127 : FIFO_DEPTH;

    typedef enum logic [1:0] {
        ST_UNCFG      = 2'd0,
        ST_WAIT_START = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    state_t state, state_next;

    logic        pkt_valid;
    logic [3:0]  pkt_port;
    logic [6:0]  pkt_aux;
    logic [31:0] pkt_payload;
    logic        is_cfg, is_data, is_credit;
    logic        unused_dest;

    assign pkt_valid   = din_leaf_bft2interface[48];
    assign pkt_port    = din_leaf_bft2interface[42:39];
    assign pkt_aux     = din_leaf_bft2interface[38:32];
    assign pkt_payload = din_leaf_bft2interface[31:0];
    assign unused_dest = ^din_leaf_bft2interface[47:43];

    assign is_cfg    = pkt_valid && (pkt_port == 4'd0);
    assign is_data   = pkt_valid && (pkt_port == 4'd1);
    assign is_credit = pkt_valid && (pkt_port == 4'd15);

    logic [4:0]  tx_leaf, src_leaf;
    logic [3:0]  tx_port, src_port;
    logic [31:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, pop, push, drop;
    logic [7:0]  tx_credits, credits_next;
    logic [8:0]  credit_sum;
    logic [7:0]  consumed, consumed_next, consumed_sum;
    logic        credit_pending, credit_due, tx_hs;
    logic [48:0] dout_next;

    // Stream handshakes: a word transfers on a rising edge where tvalid and tready are
    // both high; tvalid never depends on tready, and tready may depend only on internal state.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_tvalid  = !fifo_empty;
    assign rx_tdata   = fifo_mem[rd_ptr[AW-1:0]];
    assign pop        = rx_tvalid && rx_tready;
    // A pop frees the slot before the push lands, so full-with-pop still accepts the word.
    assign push       = is_data && (!fifo_full || pop);
    assign drop       = is_data && fifo_full && !pop;
    assign tx_hs      = tx_tvalid && tx_tready;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= pkt_payload;
    end

    always_comb begin
        credit_sum = {1'b0, tx_credits} + (is_credit ? {2'b00, pkt_aux} : 9'd0)
                   - {8'd0, tx_hs};
        credits_next = (credit_sum > 9'(INIT_CREDITS)) ? 8'(INIT_CREDITS) : credit_sum[7:0];
    end

    always_comb begin
        consumed_sum  = consumed + {7'd0, pop};
        consumed_next = consumed_sum;
        if (credit_pending)
            consumed_next = {7'd0, pop};
        else if (consumed_sum > 8'(CONS_MAX))
            consumed_next = 8'(CONS_MAX);
        credit_due = cfg_done &&
                     ((consumed >= 8'(CREDIT_BATCH)) || (resend && (consumed != 8'd0)));
    end

    always_comb begin
        dout_next = '0;
        if (credit_pending)
            dout_next = {1'b1, src_leaf, src_port, consumed[6:0], 32'h0};
        else if (tx_hs)
            dout_next = {1'b1, tx_leaf, tx_port, 7'd0, tx_tdata};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr                  <= '0;
            rd_ptr                  <= '0;
            tx_credits              <= 8'(INIT_CREDITS);
            consumed                <= '0;
            credit_pending          <= 1'b0;
            cfg_done                <= 1'b0;
            overflow                <= 1'b0;
            tx_leaf                 <= '0;
            tx_port                 <= '0;
            src_leaf                <= '0;
            src_port                <= '0;
            dout_leaf_interface2bft <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
            if (is_cfg) begin
                tx_leaf  <= pkt_payload[31:27];
                tx_port  <= pkt_payload[26:23];
                src_leaf <= pkt_payload[22:18];
                src_port <= pkt_payload[17:14];
                cfg_done <= 1'b1;
            end
            tx_credits              <= credits_next;
            consumed                <= consumed_next;
            credit_pending          <= credit_pending ? 1'b0 : credit_due;
            dout_leaf_interface2bft <= dout_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_UNCFG;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_UNCFG:      if (cfg_done) state_next = ST_WAIT_START;
            ST_WAIT_START: if (ap_start) state_next = ST_RUN;
            ST_RUN:        if (!ap_start) state_next = ST_WAIT_START;
            default:       state_next = ST_UNCFG;
        endcase
    end

    // Pending credit returns own the output slot, so they hold off the tx stream.
    always_comb begin
        tx_tready = (state == ST_RUN) && (tx_credits != 8'd0) && !credit_pending;
        dbg_state = state;
    end

endmodule

// File: tb/tb_leaf_stream_interface.sv
// Bench for leaf_stream_interface: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue/counter model of the interface.
module tb_leaf_stream_interface;

    localparam int DEPTH = 16;
    localparam int BATCH = 4;
    localparam int INIT  = 16;
    localparam int ST_UNCFG = 0, ST_WAIT = 1, ST_RUN = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [48:0] din = '0;
    logic [48:0] dout;
    logic        resend = 1'b0;
    logic        ap_start = 1'b0;
    logic [31:0] rx_tdata;
    logic        rx_tvalid;
    logic        rx_tready = 1'b0;
    logic [31:0] tx_tdata = '0;
    logic        tx_tvalid = 1'b0;
    logic        tx_tready;
    logic        cfg_done;
    logic        overflow;
    logic [1:0]  dbg_state;

    leaf_stream_interface #(
        .FIFO_DEPTH(DEPTH), .CREDIT_BATCH(BATCH), .INIT_CREDITS(INIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .din_leaf_bft2interface(din), .dout_leaf_interface2bft(dout),
        .resend(resend), .ap_start(ap_start),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .cfg_done(cfg_done), .overflow(overflow), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [31:0] m_q[$];
    int          m_credits, m_consumed, m_state;
    bit          m_pending, m_cfg, m_ovf;
    logic [4:0]  m_tx_leaf, m_src_leaf;
    logic [3:0]  m_tx_port, m_src_port;
    logic [48:0] m_dout;

    bit          last_hs, last_dut_tr, last_dut_rv;
    logic [31:0] last_dut_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [48:0] mk_pkt(input logic [4:0] leaf, input logic [3:0] port,
                                           input logic [6:0] aux, input logic [31:0] pl);
        return {1'b1, leaf, port, aux, pl};
    endfunction

    function automatic logic [48:0] cfg_pkt(input logic [4:0] tl, input logic [3:0] tp,
                                            input logic [4:0] sl, input logic [3:0] sp);
        return mk_pkt(5'd0, 4'd0, 7'd0, {tl, tp, sl, sp, 14'd0});
    endfunction

    function automatic bit exp_tready();
        return (m_state == ST_RUN) && (m_credits > 0) && !m_pending;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_credits  = INIT;
        m_consumed = 0;
        m_state    = ST_UNCFG;
        m_pending  = 1'b0;
        m_cfg      = 1'b0;
        m_ovf      = 1'b0;
        m_tx_leaf  = '0; m_tx_port  = '0;
        m_src_leaf = '0; m_src_port = '0;
        m_dout     = '0;
    endtask

    task automatic check_outputs();
        chk("dout", dout, m_dout);
        chk("rx_tvalid", rx_tvalid, m_q.size() > 0);
        if (m_q.size() > 0) chk("rx_tdata", rx_tdata, m_q[0]);
        chk("tx_tready", tx_tready, exp_tready());
        chk("cfg_done", cfg_done, m_cfg);
        chk("overflow", overflow, m_ovf);
    endtask

    // One clock cycle: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic [48:0] d, input logic rs, input logic ap,
                         input logic rr, input logic tv, input logic [31:0] td);
        bit pop, hs, npend, is_pkt;
        int c, nstate;
        last_dut_tr = tx_tready;
        last_dut_rv = rx_tvalid;
        last_dut_rd = rx_tdata;
        din = d; resend = rs; ap_start = ap; rx_tready = rr; tx_tvalid = tv; tx_tdata = td;

        pop = (m_q.size() > 0) && rr;
        hs  = tv && exp_tready();
        if (m_pending)  m_dout = {1'b1, m_src_leaf, m_src_port, 7'(m_consumed), 32'h0};
        else if (hs)    m_dout = {1'b1, m_tx_leaf, m_tx_port, 7'd0, td};
        else            m_dout = '0;

        npend = !m_pending && m_cfg && ((m_consumed >= BATCH) || (rs && m_consumed > 0));
        if (m_pending) m_consumed = int'(pop);
        else           m_consumed = (m_consumed + int'(pop) > DEPTH) ? DEPTH : m_consumed + int'(pop);
        m_pending = npend;

        is_pkt = d[48];
        if (pop) void'(m_q.pop_front());
        if (is_pkt && d[42:39] == 4'd1) begin
            if (m_q.size() < DEPTH) m_q.push_back(d[31:0]);
            else                    m_ovf = 1'b1;
        end

        c = m_credits - int'(hs) + ((is_pkt && d[42:39] == 4'd15) ? int'(d[38:32]) : 0);
        m_credits = (c > INIT) ? INIT : c;

        nstate = m_state;
        if (m_state == ST_UNCFG && m_cfg)  nstate = ST_WAIT;
        if (m_state == ST_WAIT && ap)      nstate = ST_RUN;
        if (m_state == ST_RUN && !ap)      nstate = ST_WAIT;
        m_state = nstate;

        if (is_pkt && d[42:39] == 4'd0) begin
            m_tx_leaf  = d[31:27]; m_tx_port  = d[26:23];
            m_src_leaf = d[22:18]; m_src_port = d[17:14];
            m_cfg      = 1'b1;
        end
        last_hs = hs;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n, input logic ap, input logic rr);
        for (int i = 0; i < n; i++) cycle('0, 1'b0, ap, rr, 1'b0, 32'h0);
    endtask

    task automatic tx_word(input logic [31:0] data);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cycle('0, 1'b0, 1'b1, 1'b0, 1'b1, data);
            done = last_hs;
        end
        if (!done) chk("tx_word_timeout", 1'b0, 1'b1);
    endtask

    function automatic logic [48:0] rand_pkt();
        logic [48:0] p;
        int r;
        r = $urandom_range(0, 9);
        p = '0;
        case (r)
            0, 1:       p = {1'b0, $urandom(), 16'($urandom())};
            2, 3, 4, 5: p = mk_pkt(5'($urandom()), 4'd1, 7'($urandom()), $urandom());
            6:          p = mk_pkt(5'($urandom()), 4'd15, 7'($urandom_range(0, 6)), $urandom());
            7:          p = mk_pkt(5'($urandom()), 4'($urandom_range(2, 14)), 7'($urandom()), $urandom());
            8:          if ($urandom_range(0, 4) == 0) p = mk_pkt(5'($urandom()), 4'd0, 7'($urandom()), $urandom());
            default:    p = '0;
        endcase
        return p;
    endfunction

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            cycle(rand_pkt(), $urandom_range(0, 15) == 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt, k;
        bit  seen, after;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, 49'd0);
        chk("reset_rx_tvalid", rx_tvalid, 1'b0);
        chk("reset_tx_tready", tx_tready, 1'b0);
        chk("reset_cfg_done", cfg_done, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Configuration and first transmit word
        cycle(cfg_pkt(5'd3, 4'd2, 5'd5, 4'd1), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("cfg_done_set", cfg_done, 1'b1);
        tx_word(32'hA5A5A5A5);
        chk("tx_pkt_literal", dout, {1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5A5A5});

        // Exhaust the 16 initial credits
        for (int i = 1; i < 16; i++) tx_word(32'h100 + i);
        idle(1, 1'b1, 1'b0);
        chk("tx_tready_no_credit", tx_tready, 1'b0);

        // Credit packet with aux 4 admits exactly four more words
        cnt = 0;
        cycle(mk_pkt(5'd0, 4'd15, 7'd4, 32'h0), 1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        cnt += int'(last_dut_tr);
        for (int i = 1; i < 10; i++) begin
            cycle('0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200 + i);
            cnt += int'(last_dut_tr);
        end
        chk("credit_4_words", cnt, 4);

        // Four received words consumed produce one credit-return packet
        for (int i = 0; i < 4; i++)
            cycle(mk_pkt(5'd0, 4'd1, 7'd0, 32'hD0 + i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        seen = 1'b0; after = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle(1, 1'b1, 1'b1);
            if (after) begin
                chk("credit_then_zero", dout, 49'd0);
                after = 1'b0;
            end else if (dout[48] && !seen) begin
                chk("credit_pkt_batch", dout, {1'b1, 5'd5, 4'd1, 7'd4, 32'h0});
                seen = 1'b1; after = 1'b1;
            end
        end
        chk("credit_pkt_seen", seen, 1'b1);

        // Overflow: 17 words into a 16-deep FIFO, drain yields the first 16 in order
        for (int i = 0; i < 17; i++)
            cycle(mk_pkt(5'd0, 4'd1, 7'd0, 32'h1000 + i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("overflow_set", overflow, 1'b1);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            idle(1, 1'b1, 1'b1);
            if (last_dut_rv) begin
                if (k < 16) chk("overflow_order", last_dut_rd, 32'h1000 + k);
                k++;
            end
        end
        chk("overflow_count", k, 16);

        // Flush leftovers, then resend with consumed = 2 and with consumed = 0
        idle(4, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(4, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++)
            cycle(mk_pkt(5'd0, 4'd1, 7'd0, 32'hE0 + i), 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(3, 1'b1, 1'b1);
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(1, 1'b1, 1'b1);
            if (dout[48] && !seen) begin
                chk("resend_pkt", dout, {1'b1, 5'd5, 4'd1, 7'd2, 32'h0});
                seen = 1'b1;
            end
        end
        chk("resend_pkt_seen", seen, 1'b1);
        cycle('0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1, 1'b1, 1'b1);
            cnt += int'(dout[48]);
        end
        chk("resend_zero_none", cnt, 0);

        rand_phase(2500);

        // Reset in the middle of a transmit burst
        cycle(mk_pkt(5'd0, 4'd15, 7'd16, 32'h0), 1'b0, 1'b1, 1'b0, 1'b1, 32'h300);
        for (int i = 0; i < 6; i++)
            cycle(mk_pkt(5'd0, 4'd1, 7'd0, $urandom()), 1'b0, 1'b1, 1'b0, 1'b1, 32'h300 + i);
        #2;
        reset_n = 1'b0;
        din = '0; resend = 1'b0; ap_start = 1'b0; rx_tready = 1'b0; tx_tvalid = 1'b0;
        model_reset();
        #1;
        chk("midreset_dout", dout, 49'd0);
        chk("midreset_rx_tvalid", rx_tvalid, 1'b0);
        chk("midreset_tx_tready", tx_tready, 1'b0);
        chk("midreset_cfg_done", cfg_done, 1'b0);
        chk("midreset_overflow", overflow, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Credits restart at 16 after reset
        cnt = 0;
        cycle(cfg_pkt(5'd3, 4'd2, 5'd5, 4'd1), 1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
        cnt += int'(last_dut_tr);
        for (int i = 1; i < 30; i++) begin
            cycle('0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400 + i);
            cnt += int'(last_dut_tr);
        end
        chk("post_reset_credits", cnt, 16);

        rand_phase(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
